// File: rtl/code_sequencer_if.sv
// ---------------------------------------------------------------------------
// code_sequencer_if
// Purpose : bundles the ROM table bus and the code-controller handshake that
//           the sequencer drives between controller runs.
// Signals :
//   table_data_in      ROM read data (combinational for table_address_out)
//   table_address_out  ROM address while the sequencer owns the bus
//   rom_sel_out        1 = ROM mux selects the sequencer, 0 = the controller
//   code_base_out      base address of the current code
//   ctrl_startn_out    active-low start pulse to the controller
//   ctrl_reset_out     active-high synchronous reset to the controller
//   ctrl_busy_in       controller busy
//   ctrl_fail_in       controller failure
// Modports: master = sequencer side, slave = ROM mux / controller side.
// ---------------------------------------------------------------------------
interface code_sequencer_if #(
  parameter int ADDRESS_BITS = 14
) ();
  logic [7:0]              table_data_in;
  logic [ADDRESS_BITS-1:0] table_address_out;
  logic                    rom_sel_out;
  logic [ADDRESS_BITS-1:0] code_base_out;
  logic                    ctrl_startn_out;
  logic                    ctrl_reset_out;
  logic                    ctrl_busy_in;
  logic                    ctrl_fail_in;

  modport master (
    input  table_data_in,
    input  ctrl_busy_in,
    input  ctrl_fail_in,
    output table_address_out,
    output rom_sel_out,
    output code_base_out,
    output ctrl_startn_out,
    output ctrl_reset_out
  );

  modport slave (
    output table_data_in,
    output ctrl_busy_in,
    output ctrl_fail_in,
    input  table_address_out,
    input  rom_sel_out,
    input  code_base_out,
    input  ctrl_startn_out,
    input  ctrl_reset_out
  );
endinterface

// File: rtl/code_sequencer.sv
// ---------------------------------------------------------------------------
// code_sequencer
// Purpose : walks the IR code table in ROM. For each entry it loads the code
//           base address into the controller, pulses start, waits for the
//           controller to finish, idles for GAP_CYCLES and moves on.
// Ports   :
//   clock_in        system clock
//   resetn_in       asynchronous active-low reset
//   trigger_in      starts a sweep from S_IDLE / S_DONE / S_FAIL
//   abort_in        stops the sweep (highest priority after reset)
//   bus             ROM bus + controller handshake (code_sequencer_if.master)
//   code_index_out  index of the current code
//   busy_out        sweep in progress
//   done_out        one-cycle pulse on normal sweep completion
//   fail_out        high while in S_FAIL
// Table   : byte[TABLE_BASE] = N, then N big-endian 16-bit entries.
// ---------------------------------------------------------------------------
module code_sequencer #(
  parameter int ADDRESS_BITS = 14,
  parameter int TABLE_BASE   = 0,
  parameter int GAP_CYCLES   = 1600000,
  parameter int ACK_TIMEOUT  = 15
) (
  input  logic             clock_in,
  input  logic             resetn_in,
  input  logic             trigger_in,
  input  logic             abort_in,
  code_sequencer_if.master bus,
  output logic [7:0]       code_index_out,
  output logic             busy_out,
  output logic             done_out,
  output logic             fail_out
);

  typedef enum logic [3:0] {
    S_IDLE, S_READ_COUNT, S_READ_HI, S_READ_LO, S_START,
    S_WAIT_ACK, S_WAIT_END, S_GAP, S_DONE, S_FAIL, S_ABORT
  } state_t;

  localparam logic [ADDRESS_BITS-1:0] BASE_ADDR = ADDRESS_BITS'(TABLE_BASE);
  localparam logic [ADDRESS_BITS-1:0] ONE_ADDR  = ADDRESS_BITS'(1);
  localparam logic [ADDRESS_BITS-1:0] TWO_ADDR  = ADDRESS_BITS'(2);
  localparam logic [23:0]             GAP_LAST  = 24'(GAP_CYCLES - 1);
  localparam logic [23:0]             ACK_LAST  = 24'(ACK_TIMEOUT - 1);

  state_t                  state_reg, state_next;
  logic [7:0]              count_reg, count_next;
  logic [7:0]              index_reg, index_next;
  logic [7:0]              hi_reg, hi_next;
  logic [ADDRESS_BITS-1:0] code_base_reg, code_base_next;
  logic [23:0]             wait_cnt_reg, wait_cnt_next;
  logic                    done_reg, done_next;

  logic [7:0]              index_inc;
  logic [ADDRESS_BITS-1:0] index_x2;
  logic                    in_sweep;

  logic [ADDRESS_BITS-1:0] table_address;
  logic                    rom_sel;
  logic                    ctrl_startn;
  logic                    ctrl_reset;
  logic                    busy;
  logic                    fail;

  assign index_inc = index_reg + 8'd1;
  assign index_x2  = ADDRESS_BITS'({index_reg, 1'b0});
  assign in_sweep  = !(state_reg inside {S_IDLE, S_DONE, S_FAIL});

  // State and datapath registers.
  always_ff @(posedge clock_in or negedge resetn_in) begin
    if (!resetn_in) begin
      state_reg     <= S_IDLE;
      count_reg     <= '0;
      index_reg     <= '0;
      hi_reg        <= '0;
      code_base_reg <= '0;
      wait_cnt_reg  <= '0;
      done_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      count_reg     <= count_next;
      index_reg     <= index_next;
      hi_reg        <= hi_next;
      code_base_reg <= code_base_next;
      wait_cnt_reg  <= wait_cnt_next;
      done_reg      <= done_next;
    end
  end

  // Next-state and datapath updates.
  always_comb begin
    state_next     = state_reg;
    count_next     = count_reg;
    index_next     = index_reg;
    hi_next        = hi_reg;
    code_base_next = code_base_reg;
    wait_cnt_next  = wait_cnt_reg;

    if (abort_in) begin
      // Abort leaves the datapath untouched so an abort in an idle state
      // also suppresses the index clear that a simultaneous trigger would do.
      state_next = in_sweep ? S_ABORT : S_IDLE;
    end else begin
      unique case (state_reg)
        S_IDLE, S_DONE, S_FAIL: begin
          if (trigger_in) begin
            index_next = '0;
            state_next = S_READ_COUNT;
          end
        end
        S_READ_COUNT: begin
          count_next = bus.table_data_in;
          state_next = (bus.table_data_in == 8'd0) ? S_DONE : S_READ_HI;
        end
        S_READ_HI: begin
          hi_next    = bus.table_data_in;
          state_next = S_READ_LO;
        end
        S_READ_LO: begin
          code_base_next = ADDRESS_BITS'({hi_reg, bus.table_data_in});
          state_next     = S_START;
        end
        S_START: begin
          wait_cnt_next = '0;
          state_next    = S_WAIT_ACK;
        end
        S_WAIT_ACK: begin
          if (bus.ctrl_busy_in) begin
            state_next = S_WAIT_END;
          end else if (wait_cnt_reg == ACK_LAST) begin
            state_next = S_FAIL;
          end else begin
            wait_cnt_next = wait_cnt_reg + 24'd1;
          end
        end
        S_WAIT_END: begin
          // Failure takes precedence over busy dropping in the same cycle.
          if (bus.ctrl_fail_in) begin
            state_next = S_FAIL;
          end else if (!bus.ctrl_busy_in) begin
            wait_cnt_next = '0;
            state_next    = S_GAP;
          end
        end
        S_GAP: begin
          if (wait_cnt_reg == GAP_LAST) begin
            index_next = index_inc;
            state_next = (index_inc == count_reg) ? S_DONE : S_READ_HI;
          end else begin
            wait_cnt_next = wait_cnt_reg + 24'd1;
          end
        end
        S_ABORT: state_next = S_IDLE;
        default: state_next = S_IDLE;
      endcase
    end

    // done pulses only on the entry into S_DONE, never while resting there.
    done_next = (state_next == S_DONE) && (state_reg != S_DONE);
  end

  // Moore outputs decoded from the current state.
  always_comb begin
    table_address = BASE_ADDR;
    rom_sel       = 1'b1;
    ctrl_startn   = 1'b1;
    ctrl_reset    = 1'b0;
    busy          = 1'b1;
    fail          = 1'b0;
    unique case (state_reg)
      S_IDLE: begin
        ctrl_reset = 1'b1;
        busy       = 1'b0;
      end
      S_DONE: busy = 1'b0;
      S_FAIL: begin
        busy = 1'b0;
        fail = 1'b1;
      end
      S_ABORT:    ctrl_reset = 1'b1;
      S_READ_HI:  table_address = BASE_ADDR + index_x2 + ONE_ADDR;
      S_READ_LO:  table_address = BASE_ADDR + index_x2 + TWO_ADDR;
      S_START: begin
        ctrl_startn = 1'b0;
        rom_sel     = 1'b0;
      end
      S_WAIT_END: rom_sel = 1'b0;
      default: ;
    endcase
  end

  assign bus.table_address_out = table_address;
  assign bus.rom_sel_out       = rom_sel;
  assign bus.code_base_out     = code_base_reg;
  assign bus.ctrl_startn_out   = ctrl_startn;
  assign bus.ctrl_reset_out    = ctrl_reset;
  assign code_index_out        = index_reg;
  assign busy_out              = busy;
  assign done_out              = done_reg;
  assign fail_out              = fail;

endmodule

// File: tb/tb_code_sequencer.sv
module tb_code_sequencer;
  localparam int AB       = 14;
  localparam int BASE     = 16;
  localparam int GAP      = 4;
  localparam int ACK_TO   = 15;
  localparam int BUSY_LEN = 10;

  logic       clk    = 1'b0;
  logic       resetn = 1'b1;
  logic       trigger;
  logic       abort;
  logic [7:0] code_index;
  logic       busy, done, fail;

  code_sequencer_if #(.ADDRESS_BITS(AB)) bus ();

  code_sequencer #(
    .ADDRESS_BITS(AB), .TABLE_BASE(BASE), .GAP_CYCLES(GAP), .ACK_TIMEOUT(ACK_TO)
  ) dut (
    .clock_in(clk), .resetn_in(resetn), .trigger_in(trigger), .abort_in(abort),
    .bus(bus.master), .code_index_out(code_index), .busy_out(busy),
    .done_out(done), .fail_out(fail)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ROM
  logic [7:0] rom [0:(1<<AB)-1];
  assign bus.table_data_in = rom[bus.table_address_out];

  // Controller model: busy for BUSY_LEN cycles after each sampled start.
  logic cm_busy = 1'b0, cm_fail = 1'b0;
  int   cm_left = 0, cm_starts = 0;
  logic never_ack = 1'b0;
  int   fail_code = -1;
  assign bus.ctrl_busy_in = cm_busy;
  assign bus.ctrl_fail_in = cm_fail;
  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cm_busy <= 1'b0; cm_fail <= 1'b0; cm_left <= 0;
    end else if (bus.ctrl_reset_out) begin
      cm_busy <= 1'b0; cm_fail <= 1'b0; cm_left <= 0;
    end else if (!bus.ctrl_startn_out) begin
      cm_starts <= cm_starts + 1;
      cm_fail   <= 1'b0;
      if (!never_ack) begin cm_busy <= 1'b1; cm_left <= BUSY_LEN; end
    end else if (cm_left > 1) begin
      cm_left <= cm_left - 1;
      if (cm_starts == fail_code && cm_left == 5) cm_fail <= 1'b1;
    end else begin
      cm_left <= 0; cm_busy <= 1'b0;
    end
  end

  // Scoreboard
  int n_cmp = 0, n_bad = 0;
  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Sweep model: closed-form timeline relative to the edge that samples trigger.
  // A code slot lasts 2 reads + start + ack + BUSY_LEN + GAP cycles.
  typedef struct {
    logic [AB-1:0] addr; logic rom_sel; logic [AB-1:0] base; logic startn;
    logic creset; logic [7:0] index; logic busy; logic done; logic fail;
  } exp_t;

  int            m_t0 = 0, m_n = 0, m_mode = 0;
  bit            model_en = 1'b0;
  logic [AB-1:0] m_prev;
  logic [AB-1:0] m_entry [0:7];

  function automatic exp_t model_at(int rel);
    exp_t e;
    int p, k, off, end_rel;
    p = 4 + BUSY_LEN + GAP;
    e.addr = AB'(BASE); e.rom_sel = 1'b1; e.base = m_prev; e.startn = 1'b1;
    e.creset = 1'b0; e.index = 8'd0; e.busy = 1'b1; e.done = 1'b0; e.fail = 1'b0;
    if (m_mode == 1) begin
      // controller never acknowledges: ACK_TO waiting cycles after start
      if (rel >= 3) e.base = m_entry[0];
      if (rel >= 3 + 1 + ACK_TO) begin e.busy = 1'b0; e.fail = 1'b1; end
      else if (rel == 1) e.addr = AB'(BASE + 1);
      else if (rel == 2) e.addr = AB'(BASE + 2);
      else if (rel == 3) begin e.startn = 1'b0; e.rom_sel = 1'b0; end
      return e;
    end
    end_rel = (m_n == 0) ? 1 : 3 + (m_n - 1) * p + 2 + BUSY_LEN + GAP;
    if (rel >= end_rel) begin
      e.busy = 1'b0; e.done = (rel == end_rel); e.index = 8'(m_n);
      if (m_n > 0) e.base = m_entry[m_n-1];
      return e;
    end
    if (rel == 0) return e;
    k   = (rel - 1) / p;
    off = rel - (3 + k * p);
    e.index = 8'(k);
    if (off >= 0) e.base = m_entry[k];
    else if (k > 0) e.base = m_entry[k-1];
    if (off == -2) e.addr = AB'(BASE + 1 + 2 * k);
    else if (off == -1) e.addr = AB'(BASE + 2 + 2 * k);
    else if (off == 0) begin e.startn = 1'b0; e.rom_sel = 1'b0; end
    else if (off >= 2 && off <= BUSY_LEN + 1) e.rom_sel = 1'b0;
    return e;
  endfunction

  int            start_rels[$];
  logic [AB-1:0] start_bases[$];
  int            done_rel = -1, fail_rel = -1, done_count = 0;

  always @(negedge clk) begin
    if (done) done_count <= done_count + 1;
    if (model_en && cyc >= m_t0) begin
      exp_t e;
      int   rel;
      rel = cyc - m_t0;
      e   = model_at(rel);
      if (rel == 0) begin start_rels.delete(); start_bases.delete(); done_rel = -1; fail_rel = -1; end
      check("table_address", 32'(bus.table_address_out), 32'(e.addr));
      check("rom_sel", 32'(bus.rom_sel_out), 32'(e.rom_sel));
      check("code_base", 32'(bus.code_base_out), 32'(e.base));
      check("ctrl_startn", 32'(bus.ctrl_startn_out), 32'(e.startn));
      check("ctrl_reset", 32'(bus.ctrl_reset_out), 32'(e.creset));
      check("code_index", 32'(code_index), 32'(e.index));
      check("busy_out", 32'(busy), 32'(e.busy));
      check("done_out", 32'(done), 32'(e.done));
      check("fail_out", 32'(fail), 32'(e.fail));
      if (!bus.ctrl_startn_out) begin start_rels.push_back(rel); start_bases.push_back(bus.code_base_out); end
      if (done && done_rel < 0) done_rel = rel;
      if (fail && fail_rel < 0) fail_rel = rel;
    end
  end

  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load_table(int n, int e0, int e1, int e2);
    rom[BASE]   = 8'(n);
    rom[BASE+1] = 8'(e0 >> 8); rom[BASE+2] = 8'(e0);
    rom[BASE+3] = 8'(e1 >> 8); rom[BASE+4] = 8'(e1);
    rom[BASE+5] = 8'(e2 >> 8); rom[BASE+6] = 8'(e2);
    m_entry[0] = AB'(e0); m_entry[1] = AB'(e1); m_entry[2] = AB'(e2);
  endtask

  // Called at a falling edge; returns at the falling edge where rel == 0.
  task automatic start_sweep(int mode, int n, logic [AB-1:0] prev, bit use_model);
    m_mode = mode; m_n = n; m_prev = prev; m_t0 = cyc + 1; model_en = use_model;
    trigger = 1'b1;
    tick(1);
    trigger = 1'b0;
  endtask

  task automatic check_reset_values(string tag);
    check({tag, " table_address"}, 32'(bus.table_address_out), BASE);
    check({tag, " rom_sel"}, 32'(bus.rom_sel_out), 1);
    check({tag, " code_base"}, 32'(bus.code_base_out), 0);
    check({tag, " ctrl_startn"}, 32'(bus.ctrl_startn_out), 1);
    check({tag, " ctrl_reset"}, 32'(bus.ctrl_reset_out), 1);
    check({tag, " code_index"}, 32'(code_index), 0);
    check({tag, " busy_out"}, 32'(busy), 0);
    check({tag, " done_out"}, 32'(done), 0);
    check({tag, " fail_out"}, 32'(fail), 0);
  endtask

  initial begin
    int dc, s0, guard;
    trigger = 1'b0; abort = 1'b0;
    for (int i = 0; i < (1 << AB); i++) rom[i] = 8'h00;
    load_table(2, 'h0100, 'h0200, 0);
    #1 resetn = 1'b0;
    #2 check_reset_values("reset");
    tick(3); resetn = 1'b1; tick(2);

    // A: two codes, stray trigger mid-sweep
    dc = done_count;
    start_sweep(0, 2, '0, 1'b1);
    tick(12); trigger = 1'b1; tick(1); trigger = 1'b0;
    tick(29);
    check("A starts", start_rels.size(), 2);
    if (start_rels.size() >= 2) begin
      check("A start0 cycle", start_rels[0], 3);
      check("A start1 cycle", start_rels[1], 21);
      check("A start0 base", 32'(start_bases[0]), 'h0100);
      check("A start1 base", 32'(start_bases[1]), 'h0200);
    end
    check("A done cycle", done_rel, 37);
    check("A done pulses", done_count - dc, 1);
    $display("A: two-code sweep finished, starts=%0d done_rel=%0d", start_rels.size(), done_rel);

    // B: empty table
    load_table(0, 0, 0, 0);
    start_sweep(0, 0, 'h0200, 1'b1);
    tick(5);
    check("B done cycle", done_rel, 1);
    check("B starts", start_rels.size(), 0);
    $display("B: empty table, done_rel=%0d", done_rel);

    // C: ack timeout, then restart from S_FAIL (first entry wider than the bus)
    load_table(2, 'hC321, 'h0042, 0);
    never_ack = 1'b1;
    start_sweep(1, 2, 'h0200, 1'b1);
    tick(24);
    check("C fail cycle", fail_rel, 19);
    check("C starts", start_rels.size(), 1);
    never_ack = 1'b0;
    start_sweep(0, 2, 'h0321, 1'b1);
    tick(40);
    check("C restart done cycle", done_rel, 37);
    if (start_rels.size() >= 2) begin
      check("C restart start0 base", 32'(start_bases[0]), 'h0321);
      check("C restart start1 base", 32'(start_bases[1]), 'h0042);
    end else check("C restart starts", start_rels.size(), 2);
    $display("C: timeout fail_rel=%0d, restart done_rel=%0d", fail_rel, done_rel);

    // D: controller failure during the second of three codes
    load_table(3, 'h0100, 'h0200, 'h0300);
    s0 = cm_starts; fail_code = s0 + 2;
    start_sweep(0, 3, 'h0042, 1'b0);
    guard = 0;
    while (!fail && guard < 200) begin tick(1); guard++; end
    check("D fail reached", 32'(fail), 1);
    check("D code_index", 32'(code_index), 1);
    check("D starts before fail", cm_starts - s0, 2);
    tick(40);
    check("D no third start", cm_starts - s0, 2);
    check("D busy_out", 32'(busy), 0);
    fail_code = -1;
    $display("D: controller fail, index=%0d starts=%0d", code_index, cm_starts - s0);

    // E: abort while waiting for the controller to finish
    load_table(2, 'h0100, 'h0200, 0);
    dc = done_count; s0 = cm_starts;
    start_sweep(0, 2, 'h0200, 1'b0);
    guard = 0;
    while (!(bus.rom_sel_out == 1'b0 && bus.ctrl_startn_out == 1'b1) && guard < 50) begin tick(1); guard++; end
    check("E reached wait_end", 32'(guard < 50), 1);
    tick(2); abort = 1'b1; tick(1);
    check("E abort ctrl_reset", 32'(bus.ctrl_reset_out), 1);
    check("E abort busy", 32'(busy), 1);
    abort = 1'b0; tick(1);
    check("E idle ctrl_reset", 32'(bus.ctrl_reset_out), 1);
    check("E idle busy", 32'(busy), 0);
    check("E idle rom_sel", 32'(bus.rom_sel_out), 1);
    tick(20);
    check("E no done", done_count - dc, 0);
    check("E single start", cm_starts - s0, 1);
    $display("E: abort in wait_end, busy=%0d ctrl_reset=%0d", busy, bus.ctrl_reset_out);

    // abort beats trigger when idle
    trigger = 1'b1; abort = 1'b1; tick(1); trigger = 1'b0; abort = 1'b0;
    check("abort over trigger busy", 32'(busy), 0);
    check("abort over trigger ctrl_reset", 32'(bus.ctrl_reset_out), 1);
    $display("abort+trigger in idle: busy=%0d", busy);

    // F: asynchronous reset between clock edges during the gap
    dc = done_count;
    start_sweep(0, 2, 'h0100, 1'b1);
    tick(16);
    model_en = 1'b0;
    #2 resetn = 1'b0;
    #1 check_reset_values("async");
    @(negedge clk);
    check_reset_values("held");
    resetn = 1'b1;
    tick(3);
    check("F busy after reset", 32'(busy), 0);
    check("F no done", done_count - dc, 0);
    $display("F: async reset mid-gap, busy=%0d code_base=0x%0h", busy, bus.code_base_out);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
